// File: rtl/ps2_cmd_sequencer.sv
// ps2_cmd_sequencer
//
// Host-side controller for the PS/2 keyboard link, sitting between the
// PS2_Controller core and the game logic. After reset it runs the keyboard
// init sequence (FF reset, wait ACK and BAT, then ED + LED byte). It handles
// ACK/resend/BAT responses with a response timeout and bounded retries. Once
// ready it forwards received scan codes and services LED update requests.
//
// Optional feature macro: PS2_LOCK_TRACK_EN
//   When defined, an internal {caps, num, scroll} lock register toggles on the
//   make codes 58/77/7E seen in READY. Break codes (F0-prefixed) are ignored
//   and E0 prefixes have no effect. The LED byte sent is always the lock
//   register, and led_val is ignored.
//
// Ports:
//   CLOCK_50                       in   system clock, 50 MHz
//   reset                          in   synchronous, active-low reset
//   init_req                       in   pulse: rerun full init (READY/FAIL only)
//   led_req                        in   pulse: send LED state led_val
//   led_val[2:0]                   in   {caps, num, scroll}
//   cmd_data[7:0]                  out  command byte to PS2_Controller
//   cmd_send                       out  send_command to PS2_Controller
//   command_was_sent               in   from PS2_Controller
//   error_communication_timed_out  in   from PS2_Controller
//   rx_data[7:0]                   in   received byte from PS2_Controller
//   rx_en                          in   received byte valid
//   key_data[7:0]                  out  forwarded scan code
//   key_valid                      out  one-cycle strobe for key_data
//   busy                           out  init/LED sequence in progress
//   ready                          out  keyboard initialised, forwarding on
//   fail                           out  sticky failure flag

module ps2_cmd_sequencer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic [7:0] cmd_data,
  output logic       cmd_send,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] rx_data,
  input  logic       rx_en,
  output logic [7:0] key_data,
  output logic       key_valid,
  output logic       busy,
  output logic       ready,
  output logic       fail
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES);

  typedef enum logic [3:0] {
    RST_SEND,
    RST_ACK,
    RST_BAT,
    LED_CMD,
    LED_CMD_ACK,
    LED_DATA,
    LED_DATA_ACK,
    READY,
    FAIL
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic                 pending_q, pending_d;
  logic [2:0]           led_latch_q, led_latch_d;
  logic [7:0]           cmd_data_q, cmd_data_d;
  logic                 cmd_send_q, cmd_send_d;
  logic [7:0]           key_data_q, key_data_d;
  logic                 key_valid_q, key_valid_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;
  logic                 fail_q, fail_d;

  logic                 retry_evt;
  state_t               retry_target;
  logic [7:0]           send_byte;
  state_t               ack_state;
  logic                 is_wait_state;

`ifdef PS2_LOCK_TRACK_EN
  logic [2:0]           lock_q, lock_d;
  logic                 break_q, break_d;
  logic [2:0]           lock_mask;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      state_q     <= RST_SEND;
      timer_q     <= '0;
      retry_q     <= '0;
      pending_q   <= 1'b0;
      led_latch_q <= 3'b000;
      cmd_data_q  <= 8'h00;
      cmd_send_q  <= 1'b0;
      key_data_q  <= 8'h00;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
`ifdef PS2_LOCK_TRACK_EN
      lock_q      <= 3'b000;
      break_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pending_q   <= pending_d;
      led_latch_q <= led_latch_d;
      cmd_data_q  <= cmd_data_d;
      cmd_send_q  <= cmd_send_d;
      key_data_q  <= key_data_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
`ifdef PS2_LOCK_TRACK_EN
      lock_q      <= lock_d;
      break_q     <= break_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    pending_d    = pending_q;
    led_latch_d  = led_latch_q;
    cmd_data_d   = cmd_data_q;
    cmd_send_d   = cmd_send_q;
    key_data_d   = key_data_q;
    key_valid_d  = 1'b0;
    retry_evt    = 1'b0;
    retry_target = state_q;
`ifdef PS2_LOCK_TRACK_EN
    lock_d       = lock_q;
    break_d      = 1'b0;
    lock_mask    = 3'b000;
`endif

    case (state_q)
      RST_SEND: begin
        send_byte = 8'hFF;
        ack_state = RST_ACK;
      end
      LED_CMD: begin
        send_byte = 8'hED;
        ack_state = LED_CMD_ACK;
      end
      default: begin
        send_byte = {5'b00000, led_latch_q};
        ack_state = LED_DATA_ACK;
      end
    endcase

    is_wait_state = (state_q == RST_ACK) || (state_q == RST_BAT) ||
                    (state_q == LED_CMD_ACK) || (state_q == LED_DATA_ACK);

    // Forwarding uses the current state only, so a byte arriving in the same
    // cycle READY is left is still delivered.
    if (state_q == READY && rx_en) begin
      key_data_d  = rx_data;
      key_valid_d = 1'b1;
    end

`ifdef PS2_LOCK_TRACK_EN
    // break_q remembers an F0 prefix; E0 keeps it unchanged.
    if (state_q == READY) begin
      break_d = break_q;
      if (rx_en) begin
        if (rx_data == 8'hF0) begin
          break_d = 1'b1;
        end else if (rx_data != 8'hE0) begin
          break_d = 1'b0;
          if (!break_q) begin
            case (rx_data)
              8'h58:   lock_mask = 3'b100;
              8'h77:   lock_mask = 3'b010;
              8'h7E:   lock_mask = 3'b001;
              default: lock_mask = 3'b000;
            endcase
          end
        end
      end
      lock_d = lock_q ^ lock_mask;
      if (lock_mask != 3'b000) begin
        pending_d = 1'b1;
      end
    end
`endif

    case (state_q)
      RST_SEND, LED_CMD, LED_DATA: begin
        // cmd_send is raised only from a low state, so after a drop there is
        // always at least one low cycle before the byte goes out again.
        if (!cmd_send_q) begin
          cmd_send_d = 1'b1;
          cmd_data_d = send_byte;
        end else if (command_was_sent) begin
          cmd_send_d = 1'b0;
          state_d    = ack_state;
        end else if (error_communication_timed_out) begin
          cmd_send_d   = 1'b0;
          retry_evt    = 1'b1;
          retry_target = state_q;
        end
      end

      RST_ACK, LED_CMD_ACK, LED_DATA_ACK: begin
        case (state_q)
          RST_ACK:     retry_target = RST_SEND;
          LED_CMD_ACK: retry_target = LED_CMD;
          default:     retry_target = LED_DATA;
        endcase
        if (rx_en && rx_data == 8'hFA) begin
          retry_d = '0;
          case (state_q)
            RST_ACK:     state_d = RST_BAT;
            LED_CMD_ACK: state_d = LED_DATA;
            default:     state_d = READY;
          endcase
        end else if (rx_en && rx_data == 8'hFE) begin
          retry_evt = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          retry_evt = 1'b1;
        end
      end

      RST_BAT: begin
        retry_target = RST_SEND;
        if (rx_en && rx_data == 8'hAA) begin
          state_d = LED_CMD;
        end else if (rx_en && rx_data == 8'hFC) begin
          state_d = FAIL;
        end else if (timer_q == TIMER_LAST) begin
          retry_evt = 1'b1;
        end
      end

      READY: begin
        // init wins over an LED update because init sends the LEDs anyway.
        if (init_req) begin
          state_d   = RST_SEND;
          retry_d   = '0;
          pending_d = 1'b0;
        end else if (led_req || pending_q) begin
          state_d   = LED_CMD;
          pending_d = 1'b0;
        end
      end

      FAIL: begin
        if (init_req) begin
          state_d   = RST_SEND;
          retry_d   = '0;
          pending_d = 1'b0;
        end
      end

      default: begin
        state_d = FAIL;
      end
    endcase

    if (retry_evt) begin
      if (retry_q == RETRY_LAST) begin
        state_d = FAIL;
      end else begin
        state_d = retry_target;
        retry_d = retry_q + 1'b1;
      end
    end

    if (state_d == FAIL) begin
      cmd_send_d = 1'b0;
    end

    // LED requests during a sequence are remembered and replayed from READY.
    if (led_req && state_q != READY && state_q != FAIL) begin
      pending_d = 1'b1;
    end

    if (state_d == LED_CMD && state_q != LED_CMD) begin
`ifdef PS2_LOCK_TRACK_EN
      led_latch_d = lock_d;
`else
      led_latch_d = led_val;
`endif
    end

    // Every state change restarts the response timer.
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (is_wait_state) begin
      timer_d = timer_q + 1'b1;
    end else begin
      timer_d = '0;
    end

    busy_d  = (state_d != READY) && (state_d != FAIL);
    ready_d = (state_d == READY);
    fail_d  = (state_d == FAIL);
  end

  assign cmd_data  = cmd_data_q;
  assign cmd_send  = cmd_send_q;
  assign key_data  = key_data_q;
  assign key_valid = key_valid_q;
  assign busy      = busy_q;
  assign ready     = ready_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb_ps2_cmd_sequencer
//
// Directed bench for ps2_cmd_sequencer. A short response timeout keeps the
// retry scenarios fast. Keyboard responses are driven by hand, and scan-code
// forwarding is checked from a table of {input, expected output} records.
// The expected LED bytes follow PS2_LOCK_TRACK_EN when the macro is defined.

module tb_ps2_cmd_sequencer;

  localparam int TIMEOUT = 100;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b0;
  logic       init_req = 1'b0;
  logic       led_req = 1'b0;
  logic [2:0] led_val = 3'b000;
  logic [7:0] cmd_data;
  logic       cmd_send;
  logic       command_was_sent = 1'b0;
  logic       error_communication_timed_out = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_en = 1'b0;
  logic [7:0] key_data;
  logic       key_valid;
  logic       busy;
  logic       ready;
  logic       fail;

  int total = 0;
  int bad = 0;
  int last_wait = 0;

  typedef struct {
    logic       rx_en;
    logic [7:0] rx_data;
    logic       exp_valid;
    logic [7:0] exp_data;
  } key_vec_t;

  key_vec_t vecs [8];

  ps2_cmd_sequencer #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .MAX_RETRIES(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .init_req(init_req),
    .led_req(led_req),
    .led_val(led_val),
    .cmd_data(cmd_data),
    .cmd_send(cmd_send),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out),
    .rx_data(rx_data),
    .rx_en(rx_en),
    .key_data(key_data),
    .key_valid(key_valid),
    .busy(busy),
    .ready(ready),
    .fail(fail)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %02h, wanted %02h", name, act, exp);
    end
  endtask

  // One received byte: rx_en high across exactly one sampling edge.
  task automatic applyStimulus(input logic [7:0] b);
    rx_data = b;
    rx_en = 1'b1;
    @(negedge CLOCK_50);
    rx_en = 1'b0;
  endtask

  task automatic waitCmd(output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < 400) begin
      if (cmd_send === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge CLOCK_50);
        waited++;
      end
    end
  endtask

  // Wait for a command, check its byte, then report it sent.
  task automatic expectCmd(input string name, input logic [7:0] exp_byte);
    bit seen;
    int waited;
    waitCmd(seen, waited);
    last_wait = waited;
    checkOutput({name, " seen"}, {7'd0, seen}, 8'd1);
    if (seen) begin
      checkOutput({name, " byte"}, cmd_data, exp_byte);
      command_was_sent = 1'b1;
      @(negedge CLOCK_50);
      command_was_sent = 1'b0;
      checkOutput({name, " drop"}, {7'd0, cmd_send}, 8'd0);
    end
  endtask

  task automatic quietFor(input string name, input int n);
    bit saw;
    saw = 1'b0;
    repeat (n) begin
      @(negedge CLOCK_50);
      if (cmd_send === 1'b1) saw = 1'b1;
    end
    checkOutput(name, {7'd0, saw}, 8'd0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    init_req = 1'b0;
    led_req = 1'b0;
    rx_en = 1'b0;
    command_was_sent = 1'b0;
    error_communication_timed_out = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checkOutput("rst cmd_send", {7'd0, cmd_send}, 8'd0);
    checkOutput("rst cmd_data", cmd_data, 8'h00);
    checkOutput("rst busy", {7'd0, busy}, 8'd0);
    checkOutput("rst ready", {7'd0, ready}, 8'd0);
    checkOutput("rst fail", {7'd0, fail}, 8'd0);
    checkOutput("rst key_valid", {7'd0, key_valid}, 8'd0);
    reset = 1'b1;
  endtask

  task automatic runInit(input string name, input logic [7:0] led_byte);
    expectCmd({name, " FF"}, 8'hFF);
    applyStimulus(8'hFA);
    applyStimulus(8'hAA);
    expectCmd({name, " ED"}, 8'hED);
    applyStimulus(8'hFA);
    expectCmd({name, " led"}, led_byte);
    applyStimulus(8'hFA);
    checkOutput({name, " ready"}, {7'd0, ready}, 8'd1);
    checkOutput({name, " busy"}, {7'd0, busy}, 8'd0);
  endtask

  initial begin
    logic [7:0] pend_led;
    logic [7:0] both_led;
    int n;
    bit extra;

    vecs[0] = '{1'b1, 8'h1D, 1'b1, 8'h1D};
    vecs[1] = '{1'b1, 8'hF0, 1'b1, 8'hF0};
    vecs[2] = '{1'b1, 8'h1D, 1'b1, 8'h1D};
    vecs[3] = '{1'b0, 8'h22, 1'b0, 8'h1D};
    vecs[4] = '{1'b1, 8'hE0, 1'b1, 8'hE0};
    vecs[5] = '{1'b1, 8'h75, 1'b1, 8'h75};
    vecs[6] = '{1'b1, 8'hFA, 1'b1, 8'hFA};
    vecs[7] = '{1'b0, 8'h00, 1'b0, 8'hFA};

`ifdef PS2_LOCK_TRACK_EN
    pend_led = 8'h00;
    both_led = 8'h00;
`else
    pend_led = 8'h05;
    both_led = 8'h03;
`endif

    // Plain init with led_val = 0.
    $display("[TB] init sequence");
    doReset();
    runInit("init", 8'h00);

    // Scan-code forwarding from READY, table driven.
    $display("[TB] key forwarding");
    for (int i = 0; i < 8; i++) begin
      rx_en = vecs[i].rx_en;
      rx_data = vecs[i].rx_data;
      @(negedge CLOCK_50);
      rx_en = 1'b0;
      checkOutput($sformatf("key_valid[%0d]", i), {7'd0, key_valid},
                  {7'd0, vecs[i].exp_valid});
      checkOutput($sformatf("key_data[%0d]", i), key_data, vecs[i].exp_data);
      @(negedge CLOCK_50);
      checkOutput($sformatf("key_pulse[%0d]", i), {7'd0, key_valid}, 8'd0);
    end

    // init_req and led_req together: one init, no extra LED sequence.
    $display("[TB] init with led_req");
    led_val = 3'b011;
    init_req = 1'b1;
    led_req = 1'b1;
    @(negedge CLOCK_50);
    init_req = 1'b0;
    led_req = 1'b0;
    checkOutput("both busy", {7'd0, busy}, 8'd1);
    runInit("both", both_led);
    quietFor("both no extra", 30);
    led_val = 3'b000;

    // Two resends of FF before the ACK.
    $display("[TB] resend");
    doReset();
    expectCmd("rs FF0", 8'hFF);
    applyStimulus(8'hFE);
    expectCmd("rs FF1", 8'hFF);
    applyStimulus(8'hFE);
    runInit("rs", 8'h00);
    checkOutput("rs fail", {7'd0, fail}, 8'd0);

    // Silent keyboard: four FF attempts, then failure.
    $display("[TB] timeout");
    doReset();
    for (int a = 0; a < 4; a++) begin
      expectCmd($sformatf("to FF%0d", a), 8'hFF);
      if (a > 0) begin
        total++;
        if (last_wait < TIMEOUT || last_wait > TIMEOUT + 3) begin
          bad++;
          $display("[TB] FAIL to gap%0d: got %0d cycles, wanted %0d..%0d", a,
                   last_wait, TIMEOUT, TIMEOUT + 3);
        end
      end
    end
    n = 0;
    extra = 1'b0;
    while (fail !== 1'b1 && n < 300) begin
      @(negedge CLOCK_50);
      n++;
      if (cmd_send === 1'b1) extra = 1'b1;
    end
    checkOutput("to fail", {7'd0, fail}, 8'd1);
    checkOutput("to busy", {7'd0, busy}, 8'd0);
    checkOutput("to no 5th", {7'd0, extra}, 8'd0);
    init_req = 1'b1;
    @(negedge CLOCK_50);
    init_req = 1'b0;
    checkOutput("to restart busy", {7'd0, busy}, 8'd1);
    checkOutput("to restart fail", {7'd0, fail}, 8'd0);
    expectCmd("to restart FF", 8'hFF);

    // BAT failure code.
    $display("[TB] BAT failure");
    doReset();
    expectCmd("bat FF", 8'hFF);
    applyStimulus(8'hFA);
    applyStimulus(8'hFC);
    checkOutput("bat fail", {7'd0, fail}, 8'd1);
    checkOutput("bat busy", {7'd0, busy}, 8'd0);
    quietFor("bat no ED", 30);

    // led_req during init is replayed once init completes.
    $display("[TB] pending LED");
    doReset();
    expectCmd("pend FF", 8'hFF);
    led_val = 3'b101;
    led_req = 1'b1;
    @(negedge CLOCK_50);
    led_req = 1'b0;
    applyStimulus(8'hFA);
    applyStimulus(8'hAA);
    expectCmd("pend ED", 8'hED);
    applyStimulus(8'hFA);
    expectCmd("pend led", pend_led);
    applyStimulus(8'hFA);
    checkOutput("pend ready", {7'd0, ready}, 8'd1);
    expectCmd("pend ED2", 8'hED);
    applyStimulus(8'hFA);
    expectCmd("pend led2", pend_led);
    applyStimulus(8'hFA);
    checkOutput("pend ready2", {7'd0, ready}, 8'd1);
    quietFor("pend no third", 30);

    // Caps make code: one LED update with lock tracking, none without.
    $display("[TB] caps lock");
    applyStimulus(8'h58);
    checkOutput("caps fwd", key_data, 8'h58);
`ifdef PS2_LOCK_TRACK_EN
    expectCmd("caps ED", 8'hED);
    applyStimulus(8'hFA);
    expectCmd("caps led", 8'h04);
    applyStimulus(8'hFA);
    checkOutput("caps ready", {7'd0, ready}, 8'd1);
    applyStimulus(8'hF0);
    applyStimulus(8'h58);
    quietFor("caps break quiet", 30);
`else
    quietFor("caps quiet", 30);
`endif
    checkOutput("caps ready end", {7'd0, ready}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_sequencer.md
Name: ps2_cmd_sequencer

Overview:
Host-side controller for the PS/2 keyboard link. It sits between the PS2_Controller core and the game logic.
- After reset it drives the controller's command port to run the keyboard init sequence: reset (FF), then set LEDs (ED + LED byte).
- It handles ACK, resend and BAT responses, with timeout and retry.
- Once ready, it forwards received scan codes to the key decoder and services later LED update requests.

Parameters:
TIMEOUT_CYCLES, 50_000_000, max CLOCK_50 cycles to wait for a response byte (1 s); timer width $clog2(TIMEOUT_CYCLES+1)
MAX_RETRIES, 3, resend attempts per command byte before declaring failure

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-low reset
init_req  input  1  one-cycle pulse: rerun full init sequence
led_req  input  1  one-cycle pulse: send LED state led_val
led_val  input  3  {caps, num, scroll} LED state
cmd_data  output  8  to PS2_Controller the_command
cmd_send  output  1  to PS2_Controller send_command
command_was_sent  input  1  from PS2_Controller
error_communication_timed_out  input  1  from PS2_Controller
rx_data  input  8  from PS2_Controller received_data
rx_en  input  1  from PS2_Controller received_data_en
key_data  output  8  forwarded scan code
key_valid  output  1  one-cycle strobe, key_data valid
busy  output  1  sequence in progress
ready  output  1  keyboard initialised, forwarding enabled
fail  output  1  sticky failure flag

Behaviour:
- Reset (reset==0 at a CLOCK_50 edge):
  - All outputs 0; timer, retry count and pending-LED flag cleared.
  - State = RST_SEND on the first edge with reset==1, so init starts automatically.
- States: RST_SEND, RST_ACK, RST_BAT, LED_CMD, LED_CMD_ACK, LED_DATA, LED_DATA_ACK, READY, FAIL.
- busy=1 in all states except READY and FAIL. ready=1 only in READY. fail=1 only in FAIL.
- Send states (RST_SEND=FF, LED_CMD=ED, LED_DATA={5'b0, led_val latched}):
  - cmd_data is registered and stable.
  - cmd_send stays high until command_was_sent or error_communication_timed_out is sampled high.
  - cmd_send drops on the next edge; it is never re-asserted in the same cycle.
  - command_was_sent: go to the matching ACK-wait state and clear the timer.
  - error_communication_timed_out: counts as one retry and re-enters the same send state.
- Wait states:
  - The timer increments every cycle.
  - rx_en with FA: advance (RST_ACK goes to RST_BAT; LED_CMD_ACK goes to LED_DATA; LED_DATA_ACK goes to READY).
  - FE (resend): counts as one retry and returns to the preceding send state.
  - Any other byte: ignored.
  - Timer reaches TIMEOUT_CYCLES-1: counts as one retry and returns to the preceding send state.
- RST_BAT:
  - AA goes to LED_CMD.
  - FC goes to FAIL.
  - Timeout goes to RST_SEND, counted as a retry.
- Retry counter:
  - Reset to 0 on every successful ACK.
  - A retry when count==MAX_RETRIES goes to FAIL instead.
- led_val is latched on entry to LED_CMD.
- READY:
  - rx_en drives key_data<=rx_data and key_valid<=1 on the next edge (1-cycle latency, 1-cycle pulse).
  - led_req goes to LED_CMD.
- Bytes received while busy or in FAIL are consumed and never forwarded (key_valid=0).
- led_req while busy sets the pending flag; it is serviced on entering READY (READY lasts one cycle, then LED_CMD).
- init_req:
  - Accepted only in READY or FAIL; ignored while busy.
  - Goes to RST_SEND, clears retries and the pending flag.
- init_req and led_req in the same cycle: init wins; the pending flag is cleared, since init sends led_val anyway.
- rx_en in the same cycle as a state exit from READY is still forwarded.

Optional Feature:
PS2_LOCK_TRACK_EN
- Defined:
  - An internal 3-bit lock register (reset 0) toggles on make codes 58 (caps), 77 (num) and 7E (scroll) seen in READY.
  - A make code preceded by F0 is a break code and is ignored; E0 prefix bytes are passed without effect.
  - Each toggle raises the pending flag; the LED byte sent is the lock register and led_val is ignored.
  - led_req still forces a resend of the lock register.
- Undefined: LEDs are driven only from led_val via led_req and init.

Test Plan:
1. Reset release; model returns FA after FF, then AA, FA, FA -> cmd_data sequence FF, ED, 00 (led_val=0); ready=1 after final FA; busy low.
2. Model answers FE twice to FF, then FA -> FF sent 3 times; no fail; sequence completes.
3. Model never responds (TIMEOUT_CYCLES=100) -> 4 FF attempts 100 cycles apart, then fail=1, busy=0; init_req then restarts at RST_SEND.
4. Model returns FC in RST_BAT -> fail=1 immediately; no ED sent.
5. In READY, rx_en with 1D, then F0, 1D -> key_valid pulses 3 times, one cycle after each rx_en, key_data=1D, F0, 1D.
6. led_req with led_val=3'b101 pulsed mid-init -> after init LEDs, a second ED, 05 sequence is sent; with PS2_LOCK_TRACK_EN, 58 then F0 58 in READY -> exactly one ED, 04 sequence.
